// File: rtl/draw_pkg.sv
// Shared defaults, FSM state encoding and job payload for the draw pair scheduler.
package draw_pkg;

    localparam int unsigned DEF_PAIR_W = 13;
    localparam int unsigned DEF_LEN_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Job request payload at default widths: first pair index and pair count.
    typedef struct packed {
        logic [DEF_PAIR_W-1:0] base;
        logic [DEF_LEN_W-1:0]  len;
    } job_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last-grant record.
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic gnt0_c,
    output logic gnt1_c
);

    // 1 = requester 1 was granted last; reset value gives requester 0 priority
    logic last_q;

    // On contention the requester not granted last wins
    always_comb begin
        gnt0_c = req0 & (~req1 | last_q);
        gnt1_c = req1 & (~req0 | ~last_q);
    end

    // Remember the winner only when the grant is actually taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (take && (gnt0_c || gnt1_c)) begin
            last_q <= gnt1_c;
        end
    end

endmodule

// File: rtl/draw_pair_sched.sv
// Two-requester pair-write scheduler: grants a job, emits even/odd address pairs
// under mem_ready backpressure, then pulses the owner's done.
// Optional feature macro: DRAW_SEQ_ABORT_EN adds an abort input that ends a
// running job early with a normal done pulse.
module draw_pair_sched
    import draw_pkg::*;
#(
    parameter int unsigned PAIR_W = DEF_PAIR_W,
    parameter int unsigned LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              reset,
`ifdef DRAW_SEQ_ABORT_EN
    input  logic              abort,
`endif
    input  logic              req0,
    input  logic              req1,
    input  logic [PAIR_W-1:0] base0,
    input  logic [PAIR_W-1:0] base1,
    input  logic [LEN_W-1:0]  len0,
    input  logic [LEN_W-1:0]  len1,
    input  logic              mem_ready,
    output logic              ack0,
    output logic              ack1,
    output logic              done0,
    output logic              done1,
    output logic              wr_en,
    output logic [PAIR_W:0]   Q_a,
    output logic [PAIR_W:0]   Q_b,
    output logic              busy
);

    state_e              state_q;
    logic [PAIR_W-1:0]   base_q;
    logic [LEN_W-1:0]    len_q;
    logic [PAIR_W-1:0]   ptr_q;
    logic [PAIR_W-1:0]   qptr_q;
    logic [LEN_W-1:0]    rem_q;
    logic                owner_q;
    logic                ack0_q, ack1_q, done0_q, done1_q, wr_en_q, busy_q;

    logic                gnt0_c, gnt1_c, take_c, abort_c;
    logic [PAIR_W-1:0]   sel_base_c;
    logic [LEN_W-1:0]    sel_len_c;

`ifdef DRAW_SEQ_ABORT_EN
    assign abort_c = abort;
`else
    assign abort_c = 1'b0;
`endif

    // Arbitration only counts while the FSM can accept a job
    assign take_c = (state_q == IDLE);

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0),
        .req1   (req1),
        .take   (take_c),
        .gnt0_c (gnt0_c),
        .gnt1_c (gnt1_c)
    );

    assign sel_base_c = gnt1_c ? base1 : base0;
    assign sel_len_c  = gnt1_c ? len1  : len0;

    // Main FSM: grant in IDLE, stream pairs in RUN, pulse done out of DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            ptr_q   <= '0;
            qptr_q  <= '0;
            rem_q   <= '0;
            owner_q <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt0_c || gnt1_c) begin
                        ack0_q  <= gnt0_c;
                        ack1_q  <= gnt1_c;
                        owner_q <= gnt1_c;
                        base_q  <= sel_base_c;
                        len_q   <= sel_len_c;
                        busy_q  <= 1'b1;
                        state_q <= (sel_len_c == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (!wr_en_q) begin
                        // Ack cycle: present the first pair from the next cycle on
                        wr_en_q <= 1'b1;
                        ptr_q   <= base_q;
                        qptr_q  <= base_q;
                        rem_q   <= len_q;
                    end else if (abort_c) begin
                        // A pair accepted alongside abort still counts as written
                        if (mem_ready) begin
                            ptr_q <= ptr_q + 1'b1;
                            rem_q <= rem_q - 1'b1;
                        end
                        wr_en_q <= 1'b0;
                        state_q <= DONE;
                    end else if (mem_ready) begin
                        ptr_q <= ptr_q + 1'b1;
                        rem_q <= rem_q - 1'b1;
                        if (rem_q == LEN_W'(1)) begin
                            // Last pair taken: addresses hold their final value
                            wr_en_q <= 1'b0;
                            state_q <= DONE;
                        end else begin
                            qptr_q <= ptr_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done0_q <= ~owner_q;
                    done1_q <= owner_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    wr_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack0  = ack0_q;
    assign ack1  = ack1_q;
    assign done0 = done0_q;
    assign done1 = done1_q;
    assign wr_en = wr_en_q;
    assign busy  = busy_q;
    assign Q_a   = {qptr_q, 1'b0};
    assign Q_b   = {qptr_q, 1'b1};

endmodule

// File: tb/tb_draw_pair_sched.sv
// Self-checking bench for draw_pair_sched: vector table, directed corner
// sequences and a randomized run against a transaction-level scoreboard.
module tb_draw_pair_sched;
    import draw_pkg::*;

    localparam int unsigned PW = 13;
    localparam int unsigned LW = 8;
    localparam int NPAIR = 8192;

    logic          clk;
    logic          reset;
    logic          req0, req1;
    logic [PW-1:0] base0, base1;
    logic [LW-1:0] len0, len1;
    logic          mem_ready;
    logic          ack0, ack1, done0, done1, wr_en, busy;
    logic [PW:0]   Q_a, Q_b;
`ifdef DRAW_SEQ_ABORT_EN
    logic          abort;
`endif

    int total = 0;
    int bad   = 0;

    draw_pair_sched #(.PAIR_W(PW), .LEN_W(LW)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef DRAW_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .req0      (req0),
        .req1      (req1),
        .base0     (base0),
        .base1     (base1),
        .len0      (len0),
        .len1      (len1),
        .mem_ready (mem_ready),
        .ack0      (ack0),
        .ack1      (ack1),
        .done0     (done0),
        .done1     (done1),
        .wr_en     (wr_en),
        .Q_a       (Q_a),
        .Q_b       (Q_b),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int   who;
        job_t job;
        int   mode;       // 0: mem_ready always 1, 1: ready on odd write cycles
        int   exp_wr;
        int   exp_first;
        int   exp_last;
    } vec_t;

    function automatic vec_t mk(input int who, input int base, input int len, input int mode,
                                input int ew, input int ef, input int el);
        vec_t v;
        v.who       = who;
        v.job.base  = PW'(base);
        v.job.len   = LW'(len);
        v.mode      = mode;
        v.exp_wr    = ew;
        v.exp_first = ef;
        v.exp_last  = el;
        return v;
    endfunction

    // Next negedge, with requesters dropping their line once acked
    task automatic tick();
        @(negedge clk);
        if (ack0) req0 = 1'b0;
        if (ack1) req1 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_qa",    int'(Q_a), 0);
        chk("rst_qb",    int'(Q_b), 1);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_ack",   int'({ack1, ack0}), 0);
        chk("rst_done",  int'({done1, done0}), 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int nwr, acc, first_i, done_i, first_qa, last_qa, bound, blen, bbase;
        blen  = int'(v.job.len);
        bbase = int'(v.job.base);
        bound = 2 * blen + 8;
        @(negedge clk);
        mem_ready = 1'b1;
        if (v.who == 0) begin req0 = 1'b1; base0 = v.job.base; len0 = v.job.len; end
        else            begin req1 = 1'b1; base1 = v.job.base; len1 = v.job.len; end
        @(negedge clk);
        chk("vec_ack",       v.who == 0 ? int'(ack0) : int'(ack1), 1);
        chk("vec_ack_other", v.who == 0 ? int'(ack1) : int'(ack0), 0);
        chk("vec_ack_wr",    int'(wr_en), 0);
        chk("vec_ack_busy",  int'(busy), 1);
        req0 = 1'b0;
        req1 = 1'b0;
        nwr = 0; acc = 0; first_i = -1; done_i = -1; first_qa = -1; last_qa = -1;
        for (int c = 1; c <= bound; c++) begin
            @(negedge clk);
            if (wr_en) begin
                if (first_i < 0) begin first_i = c; first_qa = int'(Q_a); end
                chk("vec_qa", int'(Q_a), 2 * ((bbase + acc) % NPAIR));
                chk("vec_qb", int'(Q_b), 2 * ((bbase + acc) % NPAIR) + 1);
                last_qa = int'(Q_a);
                mem_ready = (v.mode == 1) ? ((nwr % 2) == 1) : 1'b1;
                if (mem_ready) acc++;
                nwr++;
            end else begin
                mem_ready = 1'b1;
                if (v.who == 0 ? done0 : done1) begin
                    done_i = c;
                    chk("vec_done_busy", int'(busy), 0);
                    if (v.exp_wr > 0) chk("vec_q_hold", int'(Q_a), last_qa);
                    break;
                end
            end
        end
        chk("vec_wr_cycles", nwr, v.exp_wr);
        chk("vec_accepts", acc, blen);
        if (v.exp_wr > 0) begin
            chk("vec_first_lat", first_i, 1);
            chk("vec_first_qa", first_qa, v.exp_first);
            chk("vec_last_qa", last_qa, v.exp_last);
        end
        chk("vec_done_lat", done_i, (blen == 0) ? 1 : v.exp_wr + 2);
        @(negedge clk);
        chk("vec_done_pulse", int'({done1, done0}), 0);
    endtask

    vec_t vecs[5];

    // Scoreboard state for the randomized phase
    int exp_q[$];
    int active, owner, last_g, act_cyc, w0, w1, want, g, gen, nw, nd, a0, a1, seen;

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        base0 = '0; base1 = '0; len0 = '0; len1 = '0;
        mem_ready = 1'b1;
`ifdef DRAW_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        vecs[0] = mk(0, 1152, 128, 0, 128, 2304, 2558);
        vecs[1] = mk(1, 8190, 4,   0, 4,   16380, 2);
        vecs[2] = mk(0, 10,   0,   0, 0,   0, 0);
        vecs[3] = mk(1, 100,  3,   1, 6,   200, 204);
        vecs[4] = mk(0, 8191, 1,   0, 1,   16382, 16382);

        do_reset();
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Round robin from reset: 0 first, then 1, requests held during a job are ignored
        do_reset();
        base0 = 13'd20; len0 = 8'd2; base1 = 13'd40; len1 = 8'd2;
        req0 = 1'b1; req1 = 1'b1;
        tick();
        chk("rr_first", int'({ack1, ack0}), 1);
        nw = 0; a1 = 0; seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            tick();
            if (wr_en) nw++;
            if (ack1) a1++;
            if (done0) seen = 1;
        end
        chk("rr_done0_seen", seen, 1);
        chk("rr_job0_wr", nw, 2);
        chk("rr_no_ack_busy", a1, 0);
        req0 = 1'b1; base0 = 13'd60; len0 = 8'd1;
        tick();
        chk("rr_second", int'({ack1, ack0}), 2);
        nw = 0; a0 = 0; seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            tick();
            if (wr_en) nw++;
            if (ack0) a0++;
            if (done1) seen = 1;
        end
        chk("rr_done1_seen", seen, 1);
        chk("rr_job1_wr", nw, 2);
        chk("rr_held_req_ignored", a0, 0);
        tick();
        chk("rr_third", int'({ack1, ack0}), 1);
        nw = 0; seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            tick();
            if (wr_en) nw++;
            if (done0) seen = 1;
        end
        chk("rr_job2_wr", nw, 1);

        // Reset in the middle of a running job
        req0 = 1'b1; base0 = 13'd500; len0 = 8'd50; mem_ready = 1'b1;
        nw = 0;
        for (int c = 0; c < 20 && nw < 5; c++) begin
            tick();
            if (wr_en) nw++;
        end
        chk("rstmid_running", nw, 5);
        reset = 1'b1;
        #1;
        chk("rstmid_wr_en", int'(wr_en), 0);
        chk("rstmid_qa",    int'(Q_a), 0);
        chk("rstmid_qb",    int'(Q_b), 1);
        chk("rstmid_busy",  int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        req0 = 1'b0;
        nd = 0; nw = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (done0 || done1) nd++;
            if (wr_en) nw++;
        end
        chk("rstmid_no_done", nd, 0);
        chk("rstmid_no_wr", nw, 0);

`ifdef DRAW_SEQ_ABORT_EN
        // Abort mid-run: the accepted pair counts, done follows the DONE cycle
        req0 = 1'b1; base0 = 13'd300; len0 = 8'd20; mem_ready = 1'b1;
        nw = 0;
        for (int c = 0; c < 20 && nw < 3; c++) begin
            tick();
            if (wr_en) nw++;
        end
        chk("abort_qa_before", int'(Q_a), 604);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_wr_en", int'(wr_en), 0);
        chk("abort_busy", int'(busy), 1);
        chk("abort_qa_hold", int'(Q_a), 604);
        chk("abort_no_early_done", int'(done0), 0);
        tick();
        chk("abort_done", int'(done0), 1);
        // Abort while idle is ignored
        abort = 1'b1; req0 = 1'b1; base0 = 13'd0; len0 = 8'd2;
        tick();
        abort = 1'b0;
        chk("abort_idle_ack", int'(ack0), 1);
        nw = 0; seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            tick();
            if (wr_en) nw++;
            if (done0) seen = 1;
        end
        chk("abort_idle_wr", nw, 2);
`endif

        // Randomized traffic against a transaction-level scoreboard
        do_reset();
        last_g = 1; active = 0; owner = 0; act_cyc = 0; w0 = 0; w1 = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 3300; cyc++) begin
            gen = (cyc < 3000) ? 1 : 0;
            @(negedge clk);
            if (done0 || done1) begin
                chk("rnd_done_owner", int'({done1, done0}), (active != 0) ? ((owner == 1) ? 2 : 1) : 0);
                chk("rnd_done_drained", exp_q.size(), 0);
                active = 0;
                exp_q.delete();
            end
            if (ack0 || ack1) begin
                if (active != 0)          want = 0;
                else if (req0 && req1)    want = (last_g == 0) ? 2 : 1;
                else if (req0)            want = 1;
                else if (req1)            want = 2;
                else                      want = 0;
                chk("rnd_ack", int'({ack1, ack0}), want);
                g = ack1 ? 1 : 0;
                last_g = g; owner = g; active = 1; act_cyc = 0;
                exp_q.delete();
                for (int i = 0; i < (g == 1 ? int'(len1) : int'(len0)); i++)
                    exp_q.push_back(((g == 1 ? int'(base1) : int'(base0)) + i) % NPAIR);
                if (g == 1) begin req1 = 1'b0; w1 = 0; end
                else        begin req0 = 1'b0; w0 = 0; end
            end
            if (wr_en) begin
                chk("rnd_wr_owned", (active != 0 && exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    chk("rnd_qa", int'(Q_a), 2 * exp_q[0]);
                    chk("rnd_qb", int'(Q_b), 2 * exp_q[0] + 1);
                end
            end
            mem_ready = ($urandom_range(0, 3) != 0);
            if (wr_en && mem_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (active != 0) begin
                act_cyc++;
                if (act_cyc > 300) begin
                    chk("rnd_job_timeout", act_cyc, 300);
                    active = 0;
                end
            end
            if (req0) w0++;
            if (req1) w1++;
            if (w0 > 300) begin chk("rnd_req0_starved", w0, 300); req0 = 1'b0; w0 = 0; end
            if (w1 > 300) begin chk("rnd_req1_starved", w1, 300); req1 = 1'b0; w1 = 0; end
            if (req0 && $urandom_range(0, 31) == 0) begin
                req0 = 1'b0; w0 = 0;
            end else if (!req0 && gen != 0 && $urandom_range(0, 5) == 0) begin
                req0 = 1'b1;
                base0 = ($urandom_range(0, 3) == 0) ? PW'($urandom_range(8185, 8191)) : PW'($urandom);
                len0 = LW'($urandom_range(0, 6));
            end
            if (req1 && $urandom_range(0, 31) == 0) begin
                req1 = 1'b0; w1 = 0;
            end else if (!req1 && gen != 0 && $urandom_range(0, 5) == 0) begin
                req1 = 1'b1;
                base1 = ($urandom_range(0, 3) == 0) ? PW'($urandom_range(8185, 8191)) : PW'($urandom);
                len1 = LW'($urandom_range(0, 6));
            end
        end
        chk("rnd_end_idle", active, 0);
        chk("rnd_end_busy", int'(busy), 0);
        chk("rnd_end_reqs", int'({req1, req0}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/draw_pair_sched.md
DRAW_PAIR_SCHED -- requirements
Module: draw_pair_sched

Interface
REQ-001 Parameter PAIR_W, default 13, shall set the pair-index width; output address width is PAIR_W+1.
REQ-002 Parameter LEN_W, default 8, shall set the job-length field width, counted in pairs.
REQ-003 Port clk, input, 1: the only clock; all state shall update on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Ports req0/req1, input, 1: job request, level-held by the requester until acked.
REQ-006 Ports base0/base1, input, PAIR_W: first pair index of the job.
REQ-007 Ports len0/len1, input, LEN_W: number of pairs to write.
REQ-008 Ports ack0/ack1, output, 1: one-cycle pulse when the job is accepted.
REQ-009 Ports done0/done1, output, 1: one-cycle pulse on job completion.
REQ-010 Port mem_ready, input, 1: memory accepts the current write pair.
REQ-011 Port wr_en, output, 1: a valid write pair is present on Q_a/Q_b.
REQ-012 Ports Q_a/Q_b, output, PAIR_W+1: even address {ptr,1'b0} and odd address {ptr,1'b1}.
REQ-013 Port busy, output, 1: high when the state is not IDLE.

Function
REQ-014 The FSM shall have exactly three states: IDLE, RUN and DONE.
REQ-015 In IDLE with any reqN high, the block shall grant one requester: ackN=1 for one cycle, base/len latched in that same cycle, owner recorded.
REQ-016 Arbitration shall be round-robin: with both requests high, the requester not granted last wins.
REQ-017 After reset, requester 0 shall have priority.
REQ-018 A grant with len>0 shall move to RUN; wr_en shall be high in the first cycle after the ack.
REQ-019 A grant with len=0 shall move directly to DONE with no write cycle.
REQ-020 In RUN, wr_en shall be 1 and each cycle with mem_ready=1 shall advance ptr by 1 and decrement the remaining count by 1.
REQ-021 If mem_ready=0, ptr, Q_a and Q_b shall hold and wr_en shall stay high.
REQ-022 ptr shall wrap modulo 2^PAIR_W (all-ones + 1 gives 0).
REQ-023 When the last pair is accepted, the next state shall be DONE and wr_en shall be 0 in that next cycle.
REQ-024 DONE shall assert the owner's doneN for one cycle, then return to IDLE.
REQ-025 A new grant shall not occur in the DONE cycle.
REQ-026 When no write is in progress, Q_a/Q_b shall hold their last values.
REQ-027 A reqN that drops before its ack shall have no effect.
REQ-028 reqN sampled in RUN or DONE shall be ignored until the FSM is back in IDLE.

Reset
REQ-029 Reset shall set state=IDLE, ptr=0, Q_a=0, Q_b=1, and drive wr_en, ack0/1, done0/1 and busy to 0, with last-grant pointing at requester 1.
REQ-030 Reset asserted mid-job shall discard the job with no done pulse.

Configuration
REQ-031 Macro DRAW_SEQ_ABORT_EN defined: an input port abort (1 bit) shall exist.
REQ-032 abort=1 in RUN shall force DONE next cycle with a normal done pulse; a same-cycle mem_ready write shall count as completed.
REQ-033 abort shall be ignored in IDLE and DONE.
REQ-034 Without DRAW_SEQ_ABORT_EN, the abort port shall be absent and every job shall run to completion.

Structure
REQ-035 Package draw_pkg shall hold the PAIR_W/LEN_W defaults, the state enum (IDLE/RUN/DONE) and the job struct {base, len}.
REQ-036 Sub-module rr_arb2 shall implement the two-way round-robin grant and last-grant tracking.

Verification
REQ-037 Bench: reset, then req0 base=1152 len=128 with mem_ready=1 -> ack0 next cycle; then 128 wr_en cycles with Q_a 2304..2558 step 2 and Q_b 2305..2559; then done0 one cycle.
REQ-038 Bench: req0 and req1 high together, twice -> first grant to 0, second to 1, and no overlapping wr_en.
REQ-039 Bench: mem_ready toggling 1,0 -> ptr advances only on ready cycles and the job takes 2*len cycles.
REQ-040 Bench: base=8190 len=4 -> pair indices 8190, 8191, 0, 1 (Q_a 16380, 16382, 0, 2).
REQ-041 Bench: len=0 -> ack, then done the following cycle, and wr_en never asserted.
REQ-042 Bench: reset mid-RUN (and, with DRAW_SEQ_ABORT_EN, abort mid-RUN) -> outputs at reset values and no done; abort gives done next cycle and wr_en low.
